goertzel_tone_detect: RTL and testbench

//  Consumer of the Goertzel DFT-bin stream. Computes |X(k)|^2 = re^2 + im^2 for each
//  (re, im, valid) result frame and runs a hysteresis/debounce FSM that declares the tone

---
 rtl/goertzel_tone_detect.sv | 200 ++++++++++++++++++++
 tb/tb_goertzel_tone_detect.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_tone_detect.sv
// Goertzel bin power and tone debounce.
// Squares each (re, im) bin result, sums to |X(k)|^2, compares against
// attack/release thresholds and debounces the tone flag. Each power value is
// offered on a valid/ready record; a record arriving while the previous one is
// still pending is dropped and flagged in a sticky overrun bit.
//
// state   | meaning
// ABSENT  | no tone, waiting for a frame at/above hi
// ATTACK  | counting consecutive frames at/above hi
// PRESENT | tone declared, waiting for a frame below lo
// RELEASE | counting consecutive frames below lo (tone still reported)
module goertzel_tone_detect #(
   parameter int OW      = 32,
   parameter int PW      = 2 * OW,
   parameter int ON_CNT  = 3,
   parameter int OFF_CNT = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic signed [OW-1:0] i_re,
   input  logic signed [OW-1:0] i_im,
   input  logic        [PW-1:0] i_thresh_hi,
   input  logic        [PW-1:0] i_thresh_lo,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic        [PW-1:0] o_power,
   output logic                 o_tone,
   output logic                 o_tone_rise,
   output logic                 o_tone_fall,
   output logic                 o_overrun
);

   typedef enum logic [1:0] {
      ST_ABSENT  = 2'd0,
      ST_ATTACK  = 2'd1,
      ST_PRESENT = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   logic signed [OW-1:0] re_q, im_q;
   logic                 v0_q, v1_q, v2_q;
   logic signed [PW-1:0] re_x, im_x;
   logic        [PW-1:0] sq_re_q, sq_im_q;
   logic        [PW-1:0] sum_c, sum_q;
   logic                 above_q, below_q;
   state_t               state_q, state_d;
   logic        [7:0]    cnt_q, cnt_d;
   logic                 tone_nxt;

   // Sign-extend to the full power width so the square keeps its sign handling.
   assign re_x  = {{(PW-OW){re_q[OW-1]}}, re_q};
   assign im_x  = {{(PW-OW){im_q[OW-1]}}, im_q};
   assign sum_c = sq_re_q + sq_im_q;

   // Capture the bin result and advance the pipeline valid chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v0_q <= 1'b0;
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         re_q <= '0;
         im_q <= '0;
      end else begin
         v0_q <= i_valid;
         v1_q <= v0_q;
         v2_q <= v1_q;
         if (i_valid) begin
            re_q <= i_re;
            im_q <= i_im;
         end
      end
   end

   // Squares, then their sum with the threshold compares taken on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sq_re_q <= '0;
         sq_im_q <= '0;
         sum_q   <= '0;
         above_q <= 1'b0;
         below_q <= 1'b0;
      end else begin
         if (v0_q) begin
            sq_re_q <= re_x * re_x;
            sq_im_q <= im_x * im_x;
         end
         if (v1_q) begin
            sum_q   <= sum_c;
            above_q <= (sum_c >= i_thresh_hi);
            below_q <= (sum_c <  i_thresh_lo);
         end
      end
   end

   // Debounce state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_ABSENT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Debounce next state; only a frame reaching the last stage moves it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (v2_q) begin
         case (state_q)
            ST_ABSENT: begin
               if (above_q) begin
                  if (ON_CNT == 1) begin
                     state_d = ST_PRESENT;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_ATTACK;
                     cnt_d   = 8'd1;
                  end
               end
            end
            ST_ATTACK: begin
               if (!above_q) begin
                  state_d = ST_ABSENT;
                  cnt_d   = '0;
               end else if (cnt_q + 8'd1 == 8'(ON_CNT)) begin
                  state_d = ST_PRESENT;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
               end
            end
            ST_PRESENT: begin
               if (below_q) begin
                  if (OFF_CNT == 1) begin
                     state_d = ST_ABSENT;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_RELEASE;
                     cnt_d   = 8'd1;
                  end
               end
            end
            ST_RELEASE: begin
               if (!below_q) begin
                  state_d = ST_PRESENT;
                  cnt_d   = '0;
               end else if (cnt_q + 8'd1 == 8'(OFF_CNT)) begin
                  state_d = ST_ABSENT;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_ABSENT;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Tone level for the current and next state.
   always_comb begin
      o_tone   = (state_q == ST_PRESENT) || (state_q == ST_RELEASE);
      tone_nxt = (state_d == ST_PRESENT) || (state_d == ST_RELEASE);
   end

   // Edge pulses line up with the cycle in which o_tone changes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tone_rise <= 1'b0;
         o_tone_fall <= 1'b0;
      end else begin
         o_tone_rise <= tone_nxt & ~o_tone;
         o_tone_fall <= ~tone_nxt & o_tone;
      end
   end

   // Output record: load when the slot is free or being emptied, else drop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid   <= 1'b0;
         o_power   <= '0;
         o_overrun <= 1'b0;
      end else if (v2_q) begin
         if (!o_valid || i_ready) begin
            o_valid <= 1'b1;
            o_power <= sum_q;
         end else begin
            o_overrun <= 1'b1;
         end
      end else if (o_valid && i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_goertzel_tone_detect.sv
// Bench for goertzel_tone_detect: vector table, corner sequences and a
// randomized run, all checked against a frame-level reference model.
module tb_goertzel_tone_detect;

   localparam int OW      = 32;
   localparam int PW      = 64;
   localparam int ON_CNT  = 3;
   localparam int OFF_CNT = 3;

   logic                 i_clk;
   logic                 i_rst_n;
   logic                 i_valid;
   logic signed [OW-1:0] i_re, i_im;
   logic        [PW-1:0] i_thresh_hi, i_thresh_lo;
   logic                 o_valid;
   logic                 i_ready;
   logic        [PW-1:0] o_power;
   logic                 o_tone, o_tone_rise, o_tone_fall, o_overrun;

   goertzel_tone_detect #(.OW(OW), .PW(PW), .ON_CNT(ON_CNT), .OFF_CNT(OFF_CNT)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .i_re        (i_re),
      .i_im        (i_im),
      .i_thresh_hi (i_thresh_hi),
      .i_thresh_lo (i_thresh_lo),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_power     (o_power),
      .o_tone      (o_tone),
      .o_tone_rise (o_tone_rise),
      .o_tone_fall (o_tone_fall),
      .o_overrun   (o_overrun)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: frames in flight carry the cycle they are due out.
   typedef struct {
      int          due;
      logic [63:0] pw;
   } fr_t;
   fr_t q[$];

   logic        m_tone, m_rise, m_fall, m_ov, m_ovr;
   logic [63:0] m_pw;
   int          m_run;

   typedef struct {
      logic signed [31:0] re;
      logic signed [31:0] im;
      logic [63:0]        pw;
      logic               tone;
      logic               rise;
      logic               fall;
   } vec_t;
   vec_t vecs[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] power_of(input logic signed [31:0] re, input logic signed [31:0] im);
      longint r, m;
      r = re;
      m = im;
      return 64'(r * r) + 64'(m * m);
   endfunction

   task automatic model_reset();
      q.delete();
      m_tone = 0; m_rise = 0; m_fall = 0; m_ov = 0; m_ovr = 0;
      m_pw = '0; m_run = 0;
   endtask

   task automatic model_frame(input logic [63:0] p, input logic rdy);
      logic abv, blw;
      abv = (p >= i_thresh_hi);
      blw = (p <  i_thresh_lo);
      if (!m_tone) begin
         m_run = abv ? m_run + 1 : 0;
         if (m_run == ON_CNT) begin m_tone = 1; m_rise = 1; m_run = 0; end
      end else begin
         m_run = blw ? m_run + 1 : 0;
         if (m_run == OFF_CNT) begin m_tone = 0; m_fall = 1; m_run = 0; end
      end
      if (!m_ov || rdy) begin
         m_ov = 1;
         m_pw = p;
      end else begin
         m_ovr = 1;
      end
   endtask

   task automatic tick(input logic v, input logic signed [31:0] re, input logic signed [31:0] im,
                       input logic rdy);
      fr_t f;
      i_valid = v; i_re = re; i_im = im; i_ready = rdy;
      @(posedge i_clk);
      cyc++;
      m_rise = 0;
      m_fall = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
         f = q.pop_front();
         model_frame(f.pw, rdy);
      end else if (m_ov && rdy) begin
         m_ov = 0;
      end
      if (v) q.push_back('{cyc + 3, power_of(re, im)});
      #1;
      chk("o_valid", 64'(o_valid), 64'(m_ov));
      if (m_ov) chk("o_power", o_power, m_pw);
      chk("o_tone", 64'(o_tone), 64'(m_tone));
      chk("o_tone_rise", 64'(o_tone_rise), 64'(m_rise));
      chk("o_tone_fall", 64'(o_tone_fall), 64'(m_fall));
      chk("o_overrun", 64'(o_overrun), 64'(m_ovr));
      i_valid = 0;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) tick(0, 0, 0, rdy);
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({nm, "_valid"},   64'(o_valid), 64'd0);
      chk({nm, "_power"},   o_power,      64'd0);
      chk({nm, "_tone"},    64'(o_tone),  64'd0);
      chk({nm, "_rise"},    64'(o_tone_rise), 64'd0);
      chk({nm, "_fall"},    64'(o_tone_fall), 64'd0);
      chk({nm, "_overrun"}, 64'(o_overrun), 64'd0);
   endtask

   logic signed [31:0] smin, smax, rre, rim;

   initial begin
      smin = 32'sh8000_0000;
      smax = 32'sh7FFF_FFFF;
      vecs[0]  = '{32'sd3,  32'sd4, 64'd25,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'sd12, 32'sd0, 64'd144, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'sd12, 32'sd0, 64'd144, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'sd12, 32'sd0, 64'd144, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{32'sd3,  32'sd4, 64'd25,  1'b1, 1'b0, 1'b0};
      vecs[5]  = '{32'sd9,  32'sd0, 64'd81,  1'b1, 1'b0, 1'b0};
      vecs[6]  = '{32'sd3,  32'sd4, 64'd25,  1'b1, 1'b0, 1'b0};
      vecs[7]  = '{32'sd3,  32'sd4, 64'd25,  1'b1, 1'b0, 1'b0};
      vecs[8]  = '{32'sd3,  32'sd4, 64'd25,  1'b0, 1'b0, 1'b1};
      vecs[9]  = '{32'sd12, 32'sd0, 64'd144, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'sd12, 32'sd0, 64'd144, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'sd3,  32'sd4, 64'd25,  1'b0, 1'b0, 1'b0};
      vecs[12] = '{32'sd12, 32'sd0, 64'd144, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{smin,    smin,   64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{smax,    32'sd0, 64'h3FFF_FFFF_0000_0001, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{32'sd0,  32'sd0, 64'd0,   1'b1, 1'b0, 1'b0};
      vecs[16] = '{-32'sd1, 32'sd1, 64'd2,   1'b1, 1'b0, 1'b0};
      vecs[17] = '{smin,    smax,   64'h7FFF_FFFF_0000_0001, 1'b1, 1'b0, 1'b0};

      model_reset();
      i_rst_n = 0; i_valid = 0; i_re = 0; i_im = 0; i_ready = 1;
      i_thresh_hi = 64'd100; i_thresh_lo = 64'd50;
      #2;
      check_idle_outputs("reset");
      #20;
      i_rst_n = 1;
      idle(2, 1);

      // Vector table: one frame each, result checked as it lands 3 edges later.
      for (int k = 0; k < 18; k++) begin
         tick(1, vecs[k].re, vecs[k].im, 1);
         idle(3, 1);
         chk($sformatf("vec%0d_valid", k), 64'(o_valid), 64'd1);
         chk($sformatf("vec%0d_power", k), o_power, vecs[k].pw);
         chk($sformatf("vec%0d_tone", k), 64'(o_tone), 64'(vecs[k].tone));
         chk($sformatf("vec%0d_rise", k), 64'(o_tone_rise), 64'(vecs[k].rise));
         chk($sformatf("vec%0d_fall", k), 64'(o_tone_fall), 64'(vecs[k].fall));
      end
      idle(2, 1);

      // Backpressure: first record held, second dropped but still debounced.
      tick(1, 3, 4, 0);
      idle(1, 0);
      tick(1, 3, 4, 0);
      idle(4, 0);
      chk("bp_valid_held", 64'(o_valid), 64'd1);
      chk("bp_power_held", o_power, 64'd25);
      chk("bp_overrun", 64'(o_overrun), 64'd1);
      chk("bp_tone_still", 64'(o_tone), 64'd1);
      tick(0, 0, 0, 1);
      chk("bp_valid_clear", 64'(o_valid), 64'd0);
      tick(1, 3, 4, 1);
      idle(3, 1);
      chk("bp_third_fall", 64'(o_tone_fall), 64'd1);
      chk("bp_tone_off", 64'(o_tone), 64'd0);
      chk("bp_overrun_sticky", 64'(o_overrun), 64'd1);

      // Reset one cycle after a frame: everything clears, nothing emerges.
      tick(1, 12, 0, 1);
      i_rst_n = 0;
      #1;
      check_idle_outputs("midrst");
      model_reset();
      @(posedge i_clk);
      @(posedge i_clk);
      #2;
      i_rst_n = 1;
      idle(6, 1);
      chk("midrst_no_valid", 64'(o_valid), 64'd0);

      // Randomized: normal thresholds, then overlapping (hi < lo).
      for (int ph = 0; ph < 2; ph++) begin
         idle(4, 1);
         if (ph == 0) begin i_thresh_hi = 64'd300; i_thresh_lo = 64'd200; end
         else         begin i_thresh_hi = 64'd150; i_thresh_lo = 64'd400; end
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
               rre = $urandom;
               rim = $urandom;
            end else begin
               rre = $signed($urandom_range(0, 40)) - 32'sd20;
               rim = $signed($urandom_range(0, 40)) - 32'sd20;
            end
            tick(logic'($urandom_range(0, 1)), rre, rim, ($urandom_range(0, 3) != 0));
         end
      end
      idle(5, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
